spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI Mode 0 slave that receives 16-bit write transactions from an external host.
- Holds the five 8-bit control registers consumed by pwm_peripheral: output enables, PWM enables and duty cycle.
- Sits between the ui_in pins (SCLK, COPI, nCS) and pwm_peripheral inside the TinyTapeout top.
- All SPI inputs are asynchronous to clk; the block synchronizes them and does all logic in the clk domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk/copi/ncs (legal ≥2).
- MAX_ADDR, 4, highest mapped register address.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from ui_in[0], asynchronous.
- copi  input  1  SPI data in from ui_in[1], asynchronous.
- ncs  input  1  SPI chip select from ui_in[2], active-low, asynchronous.
- cipo  output  1  SPI data out; used only with SPI_READBACK_EN, otherwise constant 0.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, all five registers = 0x00, cipo = 0, bit counter = 0, shift register = 0, synchronizers cleared to idle (sclk=0, ncs=1).
- Synchronization: each of sclk/copi/ncs passes through SYNC_STAGES flops. A one-flop delayed copy of synced sclk/ncs gives rise/fall strobes.
- Timing requirement on SCLK: high and low phases ≥ 3 clk periods each. Faster SCLK is unsupported.
- Frame format, 16 bits MSB first, sampled on synced sclk rising edge while synced ncs=0:
  - bit15 = R/W (1 = write)
  - bits14:8 = address
  - bits7:0 = data
- States:
  - IDLE: ncs high.
  - SHIFT: ncs low; shift copi in, count rising edges. Counter saturates at 17 (over-length marker).
  - COMMIT: single cycle on synced ncs rising edge, then return to IDLE.
- Commit rules, on synced ncs rising edge:
  - Write only if count == 16, R/W = 1 and address ≤ MAX_ADDR.
  - Otherwise (short frame, over-length frame, read, unmapped address) no register changes.
  - Counter and shift register clear on every ncs falling edge and every commit.
- Latency: a written register is visible on the (SYNC_STAGES+1)th clk rising edge after raw ncs rises (3rd with default).
- Register outputs are direct flop outputs, with no glitching between commits. Only the addressed register changes.
- Simultaneous events:
  - Synced sclk edge in the same cycle as the ncs rising edge is ignored.
  - ncs falling edge during COMMIT: COMMIT completes first, then a new frame starts with count 0.
- Reset mid-frame aborts the frame; registers return to 0x00.
- Repeated writes to the same address: last complete valid frame wins.

Optional Feature:
- Macro SPI_READBACK_EN.
- Defined: frames with bit15 = 0 are reads.
  - After the 8th synced sclk rising edge, the output shift register loads the addressed register (0x00 if address > MAX_ADDR).
  - cipo drives its MSB on the next synced sclk falling edge and advances one bit per subsequent falling edge, for 8 bits.
  - cipo returns to 0 when ncs is high.
  - Reads never modify registers.
- Not defined: cipo tied 0; read frames are silently discarded; no readback logic is synthesized.

Test Plan:
- Reset: hold rst=1 for 5 clk → all five outputs 0x00, cipo=0. Release rst, no SPI activity for 100 clk → outputs unchanged.
- Basic write: frame 0x80F0 (write, addr 0x00, data 0xF0) → en_reg_out_7_0 = 0xF0 by the 3rd clk after ncs rises; others stay 0x00. Then frame 0x8480 → pwm_duty_cycle = 0x80.
- Invalid frames, none of which change any register:
  - write to addr 0x05, frame 0x85AA
  - read frame 0x01FF with macro off
  - 15-bit frame
  - 17-bit frame
- Mid-frame abort: raise ncs after 9 bits, then send full frame 0x8255 → only en_reg_pwm_7_0 = 0x55; the aborted bits do not corrupt it.
- Reset mid-frame: assert rst after 10 bits of 0x8133 → all outputs 0x00. A subsequent clean 0x8133 → en_reg_out_15_8 = 0x33.
- SPI_READBACK_EN: write 0x83A5, then read frame 0x0300 → cipo shifts out 1,0,1,0,0,1,0,1 on data-phase sclk falling edges. Read of addr 0x07 → eight 0 bits.

Source files
------------

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode 0 write slave holding five PWM control registers
// Optional read path enabled by defining SPI_READBACK_EN.
module spi_reg_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam int         NUM_REGS  = 5;
    localparam logic [6:0] MAX_A     = 7'(MAX_ADDR);
    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] OVER_LEN  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_d;
    logic                   ncs_d;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_rise;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic [7:0]  regs [0:NUM_REGS-1];

    logic        frame_ok;
    logic [6:0]  frame_addr;

    // Synchronizers reset to the idle bus level: sclk low, ncs high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    assign frame_addr = shift_reg[14:8];
    assign frame_ok   = (bit_cnt == FRAME_LEN) && shift_reg[15] && (frame_addr <= MAX_A);

    // The register write lands on the same edge that leaves SHIFT, so it is
    // visible SYNC_STAGES+1 clocks after the raw ncs rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!ncs_s) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (frame_ok && frame_addr == 7'(i)) begin
                                regs[i] <= shift_reg[7:0];
                            end
                        end
                        state     <= ST_COMMIT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (sclk_rise) begin
                        if (bit_cnt < FRAME_LEN) begin
                            shift_reg <= {shift_reg[14:0], copi_s};
                        end
                        if (bit_cnt < OVER_LEN) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    state     <= ncs_s ? ST_IDLE : ST_SHIFT;
                end
                default: begin
                    state     <= ST_IDLE;
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] header;
    logic [7:0] rd_data;
    logic [7:0] tx_shift;
    logic [3:0] tx_left;
    logic       cipo_q;

    assign sclk_fall = ~sclk_s & sclk_d;
    // Header as it will look once the 8th bit is shifted in this cycle.
    assign header    = {shift_reg[6:0], copi_s};

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (header[6:0] == 7'(i) && header[6:0] <= MAX_A) begin
                rd_data = regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            tx_left  <= '0;
            cipo_q   <= 1'b0;
        end else if (state != ST_SHIFT || ncs_rise) begin
            tx_shift <= '0;
            tx_left  <= '0;
            cipo_q   <= 1'b0;
        end else if (sclk_rise && bit_cnt == 5'd7 && !header[7]) begin
            tx_shift <= rd_data;
            tx_left  <= 4'd8;
        end else if (sclk_fall) begin
            if (tx_left != 4'd0) begin
                cipo_q   <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                tx_left  <= tx_left - 4'd1;
            end else begin
                cipo_q <= 1'b0;
            end
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - directed bench for spi_reg_slave with a frame-level register model
// Readback expectations follow SPI_READBACK_EN when defined.
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] o0, o1, o2, o3, o4;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [0:4];
    logic [7:0] rd;

    spi_reg_slave #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .cipo(cipo),
        .en_reg_out_7_0(o0),
        .en_reg_out_15_8(o1),
        .en_reg_pwm_7_0(o2),
        .en_reg_pwm_15_8(o3),
        .pwm_duty_cycle(o4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("cmp_reg0", o0, model[0]);
            check("cmp_reg1", o1, model[1]);
            check("cmp_reg2", o2, model[2]);
            check("cmp_reg3", o3, model[3]);
            check("cmp_reg4", o4, model[4]);
`ifndef SPI_READBACK_EN
            check("cmp_cipo", {7'd0, cipo}, 8'h00);
`endif
        end
    end

    task automatic send_bit(input logic b, output logic rx);
        copi = b;
        repeat (4) @(negedge clk);
        rx = cipo;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        ncs  = 1'b0;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Frame rule: exactly 16 bits, write flag set, address within the map.
    task automatic frame_end(input logic [16:0] data, input int nbits);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (nbits == 16 && data[15] && data[14:8] <= 7'd4)
            model[data[14:8]] = data[7:0];
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [16:0] data, input int nbits, output logic [7:0] rdata);
        logic rx;
        rdata = 8'h00;
        frame_start();
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(data[i], rx);
            if ((nbits - 1 - i) >= 8 && (nbits - 1 - i) <= 15)
                rdata = {rdata[6:0], rx};
        end
        frame_end(data, nbits);
    endtask

    function automatic logic [7:0] expected_read(input logic [6:0] addr);
`ifdef SPI_READBACK_EN
        return (addr <= 7'd4) ? model[addr] : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        logic rx;
        logic [15:0] w;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;

        repeat (5) @(negedge clk);
        check("rst_reg0", o0, 8'h00);
        check("rst_reg4", o4, 8'h00);
        check("rst_cipo", {7'd0, cipo}, 8'h00);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_reg0", o0, 8'h00);
        check("idle_reg2", o2, 8'h00);

        spi_frame(17'h080F0, 16, rd);
        check("lit_write_reg0", o0, 8'hF0);
        check("lit_write_reg1_untouched", o1, 8'h00);
        spi_frame(17'h08480, 16, rd);
        check("lit_write_reg4", o4, 8'h80);

        spi_frame(17'h085AA, 16, rd);
        spi_frame(17'h001FF, 16, rd);
        check("read_addr1_data", rd, expected_read(7'd1));
        spi_frame(17'h04199, 15, rd);
        spi_frame(17'h18322, 17, rd);
        check("lit_invalid_reg3", o3, 8'h00);
        check("lit_invalid_reg0", o0, 8'hF0);

        spi_frame(17'h001C2, 9, rd);
        spi_frame(17'h08255, 16, rd);
        check("lit_abort_reg2", o2, 8'h55);

        w = 16'h8133;
        frame_start();
        for (int i = 15; i >= 6; i--) send_bit(w[i], rx);
        @(negedge clk);
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("lit_midrst_reg0", o0, 8'h00);
        check("lit_midrst_reg2", o2, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        spi_frame(17'h08133, 16, rd);
        check("lit_after_rst_reg1", o1, 8'h33);

        spi_frame(17'h08411, 16, rd);
        spi_frame(17'h08477, 16, rd);
        check("lit_last_wins_reg4", o4, 8'h77);

        spi_frame(17'h083A5, 16, rd);
        spi_frame(17'h00300, 16, rd);
`ifdef SPI_READBACK_EN
        check("lit_read_addr3", rd, 8'hA5);
`else
        check("lit_read_addr3", rd, 8'h00);
`endif
        check("model_read_addr3", rd, expected_read(7'd3));
        spi_frame(17'h00700, 16, rd);
        check("lit_read_addr7", rd, 8'h00);
        check("lit_read_keeps_reg3", o3, 8'hA5);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
